led_blink_ctrl: RTL and testbench



---
 rtl/led_blink_pkg.sv | 24 ++
 rtl/led_blink_ctrl_blink_gen.sv | 61 ++++++
 rtl/led_blink_ctrl.sv | 135 +++++++++++++
 tb/tb_led_blink_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_pkg.sv
// Shared types for the LED blink controller: mode encoding, press FSM states, PWM width.
// PWM_W only matters when LED_BLINK_CTRL_PWM_EN is defined.
package led_blink_pkg;

    localparam int PWM_W = 4;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_SLOW = 2'd1,
        MODE_FAST = 2'd2,
        MODE_ON   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESSED  = 2'd1,
        REL_WAIT = 2'd2
    } press_state_t;

    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/led_blink_ctrl_blink_gen.sv
// Blink engine: half-period counter, phase flop and the raw (unregistered) LED mux.
// A mode change restarts the half-period with the LED phase lit.
module blink_gen
    import led_blink_pkg::*;
#(
    parameter int SLOW_HALF = 25_000_000,
    parameter int FAST_HALF = 6_250_000
) (
    input  logic  clk,
    input  logic  rst,
    input  mode_t mode,
    input  logic  mode_chg,
    output logic  led_raw
);

    localparam int BW = $clog2(SLOW_HALF);
    localparam logic [BW-1:0] SLOW_TC = BW'(SLOW_HALF - 1);
    localparam logic [BW-1:0] FAST_TC = BW'(FAST_HALF - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [BW-1:0] term_cnt;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        term_cnt    = (mode == MODE_FAST) ? FAST_TC : SLOW_TC;
        if (mode_chg) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (mode == MODE_SLOW || mode == MODE_FAST) begin
            if (blink_cnt_q == term_cnt) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end else begin
            blink_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    always_comb begin
        case (mode)
            MODE_OFF: led_raw = 1'b0;
            MODE_ON:  led_raw = 1'b1;
            default:  led_raw = phase_q;
        endcase
    end

endmodule

// File: rtl/led_blink_ctrl.sv
// LED blinker mode controller: classifies button presses as short/long and sequences the blink mode.
// Optional brightness PWM on the LED output is enabled by defining LED_BLINK_CTRL_PWM_EN.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   REL_WAIT | wait for button release before accepting a new press
//   IDLE     | button released, waiting for a press
//   PRESSED  | button held, hold_cnt counts high samples toward a long press
module led_blink_ctrl
    import led_blink_pkg::*;
#(
    parameter int SLOW_HALF   = 25_000_000,
    parameter int FAST_HALF   = 6_250_000,
    parameter int LONG_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
`ifdef LED_BLINK_CTRL_PWM_EN
    input  logic [PWM_W-1:0] duty,
`endif
    output logic             led,
    output logic [1:0]       mode,
    output logic             short_pulse,
    output logic             long_pulse
);

    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] LONG_TC = HW'(LONG_CYCLES - 1);

    press_state_t  state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    mode_t         mode_q, mode_d;
    logic          short_pulse_q, short_pulse_d;
    logic          long_pulse_q, long_pulse_d;
    logic          led_q, led_d;
    logic          led_raw;
    logic          mode_chg;

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        mode_d        = mode_q;
        short_pulse_d = 1'b0;
        long_pulse_d  = 1'b0;
        case (state_q)
            REL_WAIT: begin
                hold_cnt_d = '0;
                if (!btn_in) state_d = IDLE;
            end
            IDLE: begin
                if (btn_in) begin
                    state_d    = PRESSED;
                    hold_cnt_d = HW'(1);
                end
            end
            PRESSED: begin
                if (!btn_in) begin
                    state_d       = IDLE;
                    hold_cnt_d    = '0;
                    mode_d        = next_mode(mode_q);
                    short_pulse_d = 1'b1;
                end else if (hold_cnt_q == LONG_TC) begin
                    // Long press fires while still held; REL_WAIT swallows the release.
                    state_d      = REL_WAIT;
                    hold_cnt_d   = '0;
                    mode_d       = MODE_OFF;
                    long_pulse_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            default: begin
                state_d    = REL_WAIT;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Only a real change restarts the blink counter, so a long press in OFF leaves it alone.
    assign mode_chg = (mode_d != mode_q);

    blink_gen #(
        .SLOW_HALF (SLOW_HALF),
        .FAST_HALF (FAST_HALF)
    ) u_blink_gen (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode_q),
        .mode_chg (mode_chg),
        .led_raw  (led_raw)
    );

`ifdef LED_BLINK_CTRL_PWM_EN
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        led_d     = led_raw & (pwm_cnt_q < duty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_cnt_q <= '0;
        else     pwm_cnt_q <= pwm_cnt_d;
    end
`else
    always_comb begin
        led_d = led_raw;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= REL_WAIT;
            hold_cnt_q    <= '0;
            mode_q        <= MODE_OFF;
            short_pulse_q <= 1'b0;
            long_pulse_q  <= 1'b0;
            led_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            mode_q        <= mode_d;
            short_pulse_q <= short_pulse_d;
            long_pulse_q  <= long_pulse_d;
            led_q         <= led_d;
        end
    end

    assign led         = led_q;
    assign mode        = mode_q;
    assign short_pulse = short_pulse_q;
    assign long_pulse  = long_pulse_q;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl with SLOW_HALF=8, FAST_HALF=2, LONG_CYCLES=16.
// Build with LED_BLINK_CTRL_PWM_EN defined to also exercise the duty gating.
module tb_led_blink_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_in;
    logic       led;
    logic [1:0] mode;
    logic       short_pulse;
    logic       long_pulse;
`ifdef LED_BLINK_CTRL_PWM_EN
    logic [3:0] duty;
`endif

    always #5 clk = ~clk;

    led_blink_ctrl #(
        .SLOW_HALF   (8),
        .FAST_HALF   (2),
        .LONG_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
`ifdef LED_BLINK_CTRL_PWM_EN
        .duty        (duty),
`endif
        .led         (led),
        .mode        (mode),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse)
    );

    typedef struct {
        bit       btn;
        bit       led;
        bit [1:0] mode;
        bit       sp;
        bit       lp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Edges since reset release; mirrors a free-running 4-bit PWM phase.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic bit exp_led(input bit raw);
`ifdef LED_BLINK_CTRL_PWM_EN
        return raw && (((cyc - 1) % 16) < int'(duty));
`else
        return raw;
`endif
    endfunction

    task automatic add(input bit b, input bit l, input bit [1:0] m, input bit s, input bit lp);
        vec_t v;
        v.btn  = b;
        v.led  = l;
        v.mode = m;
        v.sp   = s;
        v.lp   = lp;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input bit l, input bit [1:0] m, input bit s, input bit lp);
        n_vec++;
        if (led !== l || mode !== m || short_pulse !== s || long_pulse !== lp) begin
            n_bad++;
            $display("FAIL %s: got led=%0b mode=%0d short=%0b long=%0b, expected led=%0b mode=%0d short=%0b long=%0b",
                     nm, led, mode, short_pulse, long_pulse, l, m, s, lp);
        end
    endtask

    task automatic step(input bit b);
        btn_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string nm);
        foreach (vecs[i]) begin
            step(vecs[i].btn);
            check($sformatf("%s[%0d]", nm, i), exp_led(vecs[i].led), vecs[i].mode, vecs[i].sp, vecs[i].lp);
        end
        vecs.delete();
    endtask

    initial begin
        int hi;
        rst    = 1'b1;
        btn_in = 1'b1;
`ifdef LED_BLINK_CTRL_PWM_EN
        duty   = 4'd15;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset", 1'b0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Held through reset release: ignored, then released.
        repeat (40) add(1, 0, 0, 0, 0);
        repeat (3)  add(0, 0, 0, 0, 0);
        run_table("held_thru_reset");

        // Short press into SLOW, two full blink periods.
        repeat (3) add(1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0);
        for (int p = 0; p < 32; p++) add(0, ((p / 8) % 2) == 0, 1, 0, 0);
        run_table("slow_blink");

        // Short press decided at blink_cnt=5 -> FAST, then ON, then OFF.
        repeat (2) add(0, 1, 1, 0, 0);
        repeat (3) add(1, 1, 1, 0, 0);
        add(0, 1, 2, 1, 0);
        for (int i = 0; i < 8; i++)  add(0, ((i / 2) % 2) == 0, 2, 0, 0);
        for (int i = 8; i < 11; i++) add(1, ((i / 2) % 2) == 0, 2, 0, 0);
        add(0, 0, 3, 1, 0);
        repeat (6) add(0, 1, 3, 0, 0);
        repeat (3) add(1, 1, 3, 0, 0);
        add(0, 1, 0, 1, 0);
        repeat (3) add(0, 0, 0, 0, 0);
        run_table("mode_cycle");

        // Back to FAST, then a 30-cycle hold: long press on the 16th sample.
        repeat (3) add(1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0);
        repeat (3) add(1, 1, 1, 0, 0);
        add(0, 1, 2, 1, 0);
        for (int i = 0; i < 16; i++)
            add(1, ((i / 2) % 2) == 0, (i == 15) ? 2'd0 : 2'd2, 0, i == 15);
        repeat (14) add(1, 0, 0, 0, 0);
        repeat (4)  add(0, 0, 0, 0, 0);
        run_table("long_from_fast");

        // Long press while already OFF still strobes long_pulse.
        repeat (15) add(1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1);
        repeat (4) add(1, 0, 0, 0, 0);
        repeat (2) add(0, 0, 0, 0, 0);
        run_table("long_in_off");

        // Asynchronous reset mid-blink with the button held.
        step(1);
        step(0);
        check("enter_slow", exp_led(0), 2'd1, 1'b1, 1'b0);
        step(0);
        check("slow_lit", exp_led(1), 2'd1, 1'b0, 1'b0);
        repeat (3) step(1);
        #2 rst = 1'b1;
        #1 check("async_reset", 1'b0, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check($sformatf("held_after_reset[%0d]", i), 1'b0, 2'd0, 1'b0, 1'b0);
        end
        step(0);
        check("release_after_reset", 1'b0, 2'd0, 1'b0, 1'b0);
        step(1);
        step(0);
        check("press_after_reset", exp_led(0), 2'd1, 1'b1, 1'b0);

`ifdef LED_BLINK_CTRL_PWM_EN
        step(1);
        step(0);
        step(1);
        step(0);
        check("pwm_mode_on", exp_led(1), 2'd3, 1'b1, 1'b0);
        duty = 4'd4;
        step(0);
        hi = 0;
        for (int i = 0; i < 32; i++) begin
            step(0);
            hi += int'(led);
        end
        n_vec++;
        if (hi != 8) begin
            n_bad++;
            $display("FAIL pwm_duty4: got %0d lit cycles of 32, expected 8", hi);
        end
        duty = 4'd0;
        step(0);
        hi = 0;
        for (int i = 0; i < 32; i++) begin
            step(0);
            hi += int'(led);
        end
        n_vec++;
        if (hi != 0) begin
            n_bad++;
            $display("FAIL pwm_duty0: got %0d lit cycles of 32, expected 0", hi);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
